dm_load_ctrl: RTL and testbench

- Upstream feeder for the PE data memory: accepts a word stream with a valid/ready handshake, buffers one burst, then replays it to the memory's write strobes (wea / web / wec) and write data (dina).
- The data memory auto-increments its write address on every enabled cycle and rewinds to the burst base when the enable drops. This block therefore guarantees each burst is presented as exactly cmd_len back-to-back enable cycles with no gaps.

---
 rtl/dm_load_ctrl_pkg.sv | 35 +++
 rtl/dm_burst_buf.sv | 36 +++
 rtl/dm_load_ctrl.sv | 141 ++++++++++++++
 tb/tb_dm_load_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_load_ctrl_pkg.sv
// dm_load_ctrl_pkg
// Shared definitions for the PE data-memory load controller: default data
// width, command mode encodings, FSM state encoding and the mode-to-strobe
// decode used by the controller.
package dm_load_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_WORD_W     = 2 * DEF_DATA_WIDTH;

    localparam logic [1:0] MODE_LOAD  = 2'b00;
    localparam logic [1:0] MODE_SHIFT = 2'b01;
    localparam logic [1:0] MODE_TX    = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FILL  = 2'b01,
        DRAIN = 2'b10,
        TAIL  = 2'b11
    } state_t;

    // Returns {wec, web, wea}; the reserved mode selects nothing.
    function automatic logic [2:0] mode_to_en(input logic [1:0] mode);
        logic [2:0] en;
        // NOTE: default first, then the case; every path assigns en, so no latch.
        en = 3'b000;
        case (mode)
            MODE_LOAD:  en = 3'b001;
            MODE_SHIFT: en = 3'b010;
            MODE_TX:    en = 3'b100;
            default:    en = 3'b000;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/dm_burst_buf.sv
// dm_burst_buf
// One-burst word buffer: synchronous write port, asynchronous read port
// (distributed RAM).
// Ports:
//   clk    clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  read data (combinational from raddr)
module dm_burst_buf #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset; every word is written during FILL before
    // DRAIN reads it, and a resettable array would not map to distributed RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dm_load_ctrl.sv
// dm_load_ctrl
// Buffers one burst from a valid/ready word stream, then replays it to the
// PE data memory as exactly cmd_len back-to-back write-enable cycles. dina
// lags its enable by one cycle to line up with the memory's registered
// write address.
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   cmd_valid/cmd_ready          command handshake
//   cmd_mode, cmd_len            00 LOAD(wea) 01 SHIFT(web) 10 TX(wec); length 1..MAX_LEN
//   s_valid/s_ready/s_data       stream word handshake
//   wea, web, wec, dina          memory write strobes and write data
//   busy                         high whenever not IDLE
//   done                         one-cycle pulse at burst completion
//   err                          one-cycle pulse after an illegal command
module dm_load_ctrl
    import dm_load_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_LEN    = 64,
    parameter int LEN_W      = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_mode,
    input  logic [LEN_W-1:0]        cmd_len,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [2*DATA_WIDTH-1:0] s_data,
    output logic                    wea,
    output logic                    web,
    output logic                    wec,
    output logic [2*DATA_WIDTH-1:0] dina,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int WORD_W = 2 * DATA_WIDTH;
    localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    state_t            state;
    logic [1:0]        mode_q;
    logic [ADDR_W-1:0] len_m1;   // burst length minus one
    logic [ADDR_W-1:0] cnt;      // write index in FILL, read index in DRAIN
    logic [2:0]        en_q;     // {wec, web, wea}
    logic [WORD_W-1:0] rd_word;
    logic              cmd_fire;
    logic              cmd_bad;
    logic              wr_en;

    assign cmd_fire = cmd_valid && cmd_ready;
    assign cmd_bad  = (cmd_len == '0) || (cmd_len > LEN_W'(MAX_LEN)) || (cmd_mode == 2'b11);
    assign wr_en    = (state == FILL) && s_valid && s_ready;

    assign {wec, web, wea} = en_q;
    assign busy            = (state != IDLE);

    dm_burst_buf #(
        .WIDTH  (WORD_W),
        .DEPTH  (MAX_LEN),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk   (clk),
        .we    (wr_en),
        .waddr (cnt),
        .wdata (s_data),
        .raddr (cnt),
        .rdata (rd_word)
    );

    // NOTE: all state and outputs here use <= so every register samples the
    // pre-edge values; blocking assignments would create order-dependent races.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            mode_q    <= MODE_LOAD;
            len_m1    <= '0;
            cnt       <= '0;
            en_q      <= 3'b000;
            cmd_ready <= 1'b0;
            s_ready   <= 1'b0;
            dina      <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    // Re-arms one cycle after entering IDLE, so a command can
                    // never be taken in the done cycle.
                    cmd_ready <= 1'b1;
                    if (cmd_fire) begin
                        cmd_ready <= 1'b0;
                        mode_q    <= cmd_mode;
                        len_m1    <= ADDR_W'(cmd_len - LEN_W'(1));
                        if (cmd_bad) begin
                            err <= 1'b1;
                        end else begin
                            state   <= FILL;
                            cnt     <= '0;
                            s_ready <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (wr_en) begin
                        if (cnt == len_m1) begin
                            state   <= DRAIN;
                            cnt     <= '0;
                            s_ready <= 1'b0;
                            en_q    <= mode_to_en(mode_q);
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // Word k appears one cycle after enable cycle k.
                    dina <= rd_word;
                    if (cnt == len_m1) begin
                        state <= TAIL;
                        en_q  <= 3'b000;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                TAIL: begin
                    state <= IDLE;
                    cnt   <= '0;
                    dina  <= '0;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_load_ctrl.sv
// tb_dm_load_ctrl
// Directed bench for dm_load_ctrl: reset, LOAD/SHIFT/TX bursts, stream gaps,
// maximum length, illegal commands, reset mid-drain and command back-pressure.
module tb_dm_load_ctrl;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_mode;
    logic [6:0]  cmd_len;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        wea, web, wec;
    logic [31:0] dina;
    logic        busy, done, err;

    int n_checks;
    int n_fail;

    logic [31:0] words [64];

    logic [2:0]  cap_en     [80];
    logic [31:0] cap_dina   [80];
    logic        cap_done   [80];
    logic        cap_busy   [80];
    logic        cap_sready [80];
    logic        cap_cready [80];
    logic        cap_err    [80];

    dm_load_ctrl #(
        .DATA_WIDTH (16),
        .MAX_LEN    (64),
        .LEN_W      (7)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_len   (cmd_len),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .wea       (wea),
        .web       (web),
        .wec       (wec),
        .dina      (dina),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Records outputs of the current cycle, then advances one cycle.
    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            cap_en[i]     = {wec, web, wea};
            cap_dina[i]   = dina;
            cap_done[i]   = done;
            cap_busy[i]   = busy;
            cap_sready[i] = s_ready;
            cap_cready[i] = cmd_ready;
            cap_err[i]    = err;
            tick();
        end
    endtask

    task automatic send_cmd(input logic [1:0] m, input logic [6:0] l, input string name);
        int waited;
        waited    = 0;
        cmd_mode  = m;
        cmd_len   = l;
        cmd_valid = 1'b1;
        while (!cmd_ready && waited < 100) begin
            tick();
            waited++;
        end
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_cmd_accept: cmd_ready got %b want 1 within 100 cycles", name, cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    // gap_pat bit i set holds s_valid low on step i.
    task automatic stream(input int n, input logic [15:0] gap_pat, input string name);
        int   idx;
        int   step;
        logic rdy;
        idx  = 0;
        step = 0;
        while (idx < n && step < n + 200) begin
            s_valid = !(step < 16 && gap_pat[step]);
            s_data  = words[idx];
            rdy     = s_ready;
            tick();
            if (s_valid && rdy) idx++;
            step++;
        end
        s_valid = 1'b0;
        s_data  = '0;
        n_checks++;
        if (idx != n) begin
            n_fail++;
            $display("FAIL %s_stream: accepted got %0d want %0d", name, idx, n);
        end
    endtask

    // Checks a capture that started at drain cycle D0 of an n-word burst.
    task automatic verify_burst(input string name, input logic [1:0] mode, input int n);
        logic [2:0]  one;
        logic [2:0]  exp_en;
        logic [31:0] exp_d;
        one = 3'b001;
        for (int i = 0; i <= n + 1; i++) begin
            exp_en = (i < n) ? (one << mode) : 3'b000;
            exp_d  = (i >= 1 && i <= n) ? words[i-1] : 32'h0;
            n_checks++;
            if (cap_en[i] !== exp_en) begin
                n_fail++;
                $display("FAIL %s_en[%0d]: {wec,web,wea} got %b want %b", name, i, cap_en[i], exp_en);
            end
            n_checks++;
            if (cap_dina[i] !== exp_d) begin
                n_fail++;
                $display("FAIL %s_dina[%0d]: got %h want %h", name, i, cap_dina[i], exp_d);
            end
            n_checks++;
            if (cap_done[i] !== (i == n + 1)) begin
                n_fail++;
                $display("FAIL %s_done[%0d]: got %b want %b", name, i, cap_done[i], (i == n + 1));
            end
            n_checks++;
            if (cap_busy[i] !== (i <= n)) begin
                n_fail++;
                $display("FAIL %s_busy[%0d]: got %b want %b", name, i, cap_busy[i], (i <= n));
            end
            n_checks++;
            if (cap_sready[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_s_ready[%0d]: got %b want 0", name, i, cap_sready[i]);
            end
        end
    endtask

    task automatic test_reset;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_mode  = 2'b00;
        cmd_len   = '0;
        s_valid   = 1'b0;
        s_data    = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({cmd_ready, s_ready, wea, web, wec, busy, done, err} !== 8'h00 || dina !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: {cmd_ready,s_ready,wea,web,wec,busy,done,err} got %b dina %h want 00000000 dina 0",
                     {cmd_ready, s_ready, wea, web, wec, busy, done, err}, dina);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if (cmd_ready !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: cmd_ready/s_ready/busy got %b%b%b want 100", cmd_ready, s_ready, busy);
        end
    endtask

    task automatic test_load;
        for (int i = 0; i < 4; i++) words[i] = 32'h1111_1111 * (i + 1);
        send_cmd(2'b00, 7'd4, "load");
        n_checks++;
        if (s_ready !== 1'b1 || busy !== 1'b1 || {wec, web, wea} !== 3'b000) begin
            n_fail++;
            $display("FAIL load_fill: s_ready/busy/en got %b%b%b want 11000", s_ready, busy, {wec, web, wea});
        end
        stream(4, 16'h0000, "load");
        capture(7);
        verify_burst("load", 2'b00, 4);
        n_checks++;
        if (cap_cready[6] !== 1'b1 || cap_cready[5] !== 1'b0) begin
            n_fail++;
            $display("FAIL load_cmd_ready_rearm: done cycle/next got %b%b want 01", cap_cready[5], cap_cready[6]);
        end
    endtask

    task automatic test_shift_gaps;
        words[0] = 32'hAAAA_0001;
        words[1] = 32'hBBBB_0002;
        words[2] = 32'hCCCC_0003;
        send_cmd(2'b01, 7'd3, "shift");
        stream(3, 16'h0006, "shift");
        n_checks++;
        if (s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL shift_s_ready_after_last: got %b want 0", s_ready);
        end
        capture(5);
        verify_burst("shift", 2'b01, 3);
    endtask

    task automatic test_tx_max;
        for (int i = 0; i < 64; i++) words[i] = i;
        send_cmd(2'b10, 7'd64, "tx");
        stream(64, 16'h0000, "tx");
        capture(66);
        verify_burst("tx", 2'b10, 64);
    endtask

    task automatic test_illegal;
        logic [1:0] modes [3];
        logic [6:0] lens  [3];
        modes[0] = 2'b00; lens[0] = 7'd0;
        modes[1] = 2'b00; lens[1] = 7'd65;
        modes[2] = 2'b11; lens[2] = 7'd4;
        for (int t = 0; t < 3; t++) begin
            send_cmd(modes[t], lens[t], "illegal");
            capture(5);
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (cap_err[i] !== (i == 0)) begin
                    n_fail++;
                    $display("FAIL illegal%0d_err[%0d]: got %b want %b", t, i, cap_err[i], (i == 0));
                end
                n_checks++;
                if (cap_en[i] !== 3'b000 || cap_sready[i] !== 1'b0 || cap_busy[i] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL illegal%0d_quiet[%0d]: en/s_ready/busy got %b%b%b want 00000",
                             t, i, cap_en[i], cap_sready[i], cap_busy[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 8; i++) words[i] = 32'hD000_0000 + i;
        send_cmd(2'b00, 7'd8, "rstmid");
        stream(8, 16'h0000, "rstmid");
        tick();
        tick();
        n_checks++;
        if (wea !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_at_d2: wea got %b want 1", wea);
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (wea !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0 || dina !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmid_abort: wea/busy/cmd_ready got %b%b%b dina %h want 000 dina 0",
                     wea, busy, cmd_ready, dina);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        capture(12);
        for (int i = 0; i < 12; i++) begin
            n_checks++;
            if (cap_done[i] !== 1'b0 || cap_en[i] !== 3'b000 || cap_busy[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_quiet[%0d]: done/en/busy got %b%b%b want 000000",
                         i, cap_done[i], cap_en[i], cap_busy[i]);
            end
        end
        words[0] = 32'h0BAD_F00D;
        words[1] = 32'h1234_5678;
        send_cmd(2'b00, 7'd2, "reload");
        stream(2, 16'h0000, "reload");
        capture(4);
        verify_burst("reload", 2'b00, 2);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 3; i++) words[i] = 32'hE000_0100 + i;
        send_cmd(2'b00, 7'd3, "b2b");
        stream(3, 16'h0000, "b2b");
        cmd_mode  = 2'b01;
        cmd_len   = 7'd2;
        cmd_valid = 1'b1;
        capture(6);
        cmd_valid = 1'b0;
        verify_burst("b2b_first", 2'b00, 3);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (cap_cready[i] !== (i == 5)) begin
                n_fail++;
                $display("FAIL b2b_cmd_ready[%0d]: got %b want %b", i, cap_cready[i], (i == 5));
            end
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({wec, web, wea} !== 3'b000 || s_ready !== 1'b1 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_wait_fill[%0d]: en/s_ready/busy got %b%b%b want 00011",
                         i, {wec, web, wea}, s_ready, busy);
            end
            tick();
        end
        words[0] = 32'h5EC0_0001;
        words[1] = 32'h5EC0_0002;
        stream(2, 16'h0000, "b2b_second");
        capture(4);
        verify_burst("b2b_second", 2'b01, 2);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_load();
        test_shift_gaps();
        test_tx_max();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
